// File: rtl/gol_gen_sequencer.sv
// Sequences the Game of Life row register file through whole generations,
// holding computed rows back until no remaining read still needs the old row.
module gol_gen_sequencer #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned REGBITS = 3,
  parameter int unsigned GENBITS = 8
) (
  input  logic               ph1,
  input  logic               reset,
  input  logic               start,
  input  logic [GENBITS-1:0] gens,
  input  logic               load_valid,
  input  logic [REGBITS-1:0] load_addr,
  input  logic [WIDTH-1:0]   load_data,
  output logic               load_ready,
  input  logic [REGBITS-1:0] rd_addr,
  input  logic [WIDTH-1:0]   next_row,
  output logic [REGBITS-1:0] ra,
  output logic               regwrite,
  output logic [REGBITS-1:0] wa,
  output logic [WIDTH-1:0]   wd,
  output logic               busy,
  output logic               done,
  output logic [GENBITS-1:0] gen_count
);

  localparam int unsigned N = 1 << REGBITS;

  typedef enum logic [1:0] {IDLE, CALC, FLUSH, DONE} state_t;

  state_t             state, state_n;
  logic [REGBITS-1:0] r, r_n;
  logic [1:0]         f, f_n;
  logic [WIDTH-1:0]   nb0, nb0_n, nb1, nb1_n, save0, save0_n;
  logic [GENBITS-1:0] gcnt, gcnt_n, gen_count_n;

  // State register
  always_ff @(posedge ph1) begin
    if (reset) begin
      state     <= IDLE;
      r         <= '0;
      f         <= '0;
      nb0       <= '0;
      nb1       <= '0;
      save0     <= '0;
      gcnt      <= '0;
      gen_count <= '0;
    end else begin
      state     <= state_n;
      r         <= r_n;
      f         <= f_n;
      nb0       <= nb0_n;
      nb1       <= nb1_n;
      save0     <= save0_n;
      gcnt      <= gcnt_n;
      gen_count <= gen_count_n;
    end
  end

  // Next state and output decode
  always_comb begin
    state_n     = state;
    r_n         = r;
    f_n         = f;
    nb0_n       = nb0;
    nb1_n       = nb1;
    save0_n     = save0;
    gcnt_n      = gcnt;
    gen_count_n = gen_count;
    load_ready  = 1'b0;
    ra          = r;
    regwrite    = 1'b0;
    wa          = '0;
    wd          = '0;
    busy        = 1'b0;
    done        = 1'b0;

    case (state)
      IDLE: begin
        load_ready = 1'b1;
        ra         = rd_addr;
        regwrite   = load_valid;
        wa         = load_addr;
        wd         = load_data;
        if (start) begin
          gcnt_n      = gens;
          gen_count_n = '0;
          r_n         = '0;
          state_n     = (gens == '0) ? DONE : CALC;
        end
      end

      CALC: begin
        busy  = 1'b1;
        nb1_n = nb0;
        nb0_n = next_row;
        if (r == '0) save0_n = next_row;
        // Row r-2 is no longer read once the window has moved past r-1
        if (r >= REGBITS'(3)) begin
          regwrite = 1'b1;
          wa       = r - REGBITS'(2);
          wd       = nb1;
        end
        if (r == REGBITS'(N - 1)) begin
          f_n     = '0;
          state_n = FLUSH;
        end else begin
          r_n = r + REGBITS'(1);
        end
      end

      FLUSH: begin
        busy     = 1'b1;
        regwrite = 1'b1;
        case (f)
          2'd0: begin
            wa  = REGBITS'(N - 2);
            wd  = nb1;
            f_n = 2'd1;
          end
          2'd1: begin
            wa  = REGBITS'(N - 1);
            wd  = nb0;
            f_n = 2'd2;
          end
          default: begin
            wa          = '0;
            wd          = save0;
            gen_count_n = gen_count + GENBITS'(1);
            gcnt_n      = gcnt - GENBITS'(1);
            f_n         = '0;
            r_n         = '0;
            state_n     = (gcnt == GENBITS'(1)) ? DONE : CALC;
          end
        endcase
      end

      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gol_gen_sequencer.sv
// Bench for gol_gen_sequencer: register-file model plus Life next-row logic,
// with an in-order scoreboard of expected writes and done pulses.
module tb_gol_gen_sequencer;

  logic       ph1 = 1'b0;
  logic       reset, start, load_valid, load_ready;
  logic [7:0] gens, load_data, next_row, wd, gen_count;
  logic [2:0] load_addr, rd_addr, ra, wa;
  logic       regwrite, busy, done;

  gol_gen_sequencer #(.WIDTH(8), .REGBITS(3), .GENBITS(8)) dut (
    .ph1(ph1), .reset(reset), .start(start), .gens(gens),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .load_ready(load_ready), .rd_addr(rd_addr), .next_row(next_row),
    .ra(ra), .regwrite(regwrite), .wa(wa), .wd(wd),
    .busy(busy), .done(done), .gen_count(gen_count)
  );

  always #5 ph1 = ~ph1;

  typedef struct packed {
    logic       is_done;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t        q[$];
  ev_t        mon_e;
  logic [7:0] mem [8];
  logic [7:0] gold [8];
  int         n_vec = 0;
  int         n_err = 0;
  int         busy_cycles = 0;

  function automatic logic [7:0] life(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    logic [7:0] o;
    logic [2:0] l, h;
    int         cnt;
    for (int i = 0; i < 8; i++) begin
      l    = 3'(i + 7);
      h    = 3'(i + 1);
      cnt  = int'(a[l]) + int'(a[i]) + int'(a[h]) + int'(b[l]) + int'(b[h]) +
             int'(c[l]) + int'(c[i]) + int'(c[h]);
      o[i] = (cnt == 3) || (b[i] && cnt == 2);
    end
    return o;
  endfunction

  // Register file: combinational reads around ra, one write per edge
  always @(posedge ph1) if (regwrite === 1'b1) mem[wa] <= wd;
  assign next_row = life(mem[ra - 3'd1], mem[ra], mem[ra + 3'd1]);

  function automatic ev_t mk_ev(input logic d, input int a, input logic [7:0] v);
    ev_t e;
    e.is_done = d;
    e.addr    = 8'(a);
    e.data    = v;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every write and done pulse must match the head of the queue
  always @(negedge ph1) begin
    if (busy === 1'b1) busy_cycles++;
    if (regwrite === 1'b1) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: wa=%0d wd=%h, nothing expected", wa, wd);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.is_done || mon_e.addr != 8'(wa) || mon_e.data != wd) begin
          n_err++;
          $display("FAIL write: got wa=%0d wd=%h, expected done=%0b addr=%0d data=%h",
                   wa, wd, mon_e.is_done, mon_e.addr, mon_e.data);
        end
      end
    end
    if (done === 1'b1) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: gen_count=%0d, nothing expected", gen_count);
      end else begin
        mon_e = q.pop_front();
        if (!mon_e.is_done || mon_e.data != gen_count) begin
          n_err++;
          $display("FAIL done: got done with gen_count=%0d, expected done=%0b value=%0d",
                   gen_count, mon_e.is_done, mon_e.data);
        end
      end
    end
  end

  // Golden model: next generations from the bench copy, written 1..7 then 0
  task automatic push_gens(input int g);
    logic [7:0] nx [8];
    for (int gi = 0; gi < g; gi++) begin
      for (int k = 0; k < 8; k++)
        nx[k] = life(gold[(k + 7) % 8], gold[k], gold[(k + 1) % 8]);
      for (int k = 1; k <= 8; k++) q.push_back(mk_ev(1'b0, k % 8, nx[k % 8]));
      for (int k = 0; k < 8; k++) gold[k] = nx[k];
    end
  endtask

  task automatic load_row(input int a, input logic [7:0] d);
    load_valid = 1'b1;
    load_addr  = 3'(a);
    load_data  = d;
    q.push_back(mk_ev(1'b0, a, d));
    gold[a] = d;
    @(posedge ph1);
    #1 load_valid = 1'b0;
  endtask

  task automatic load_all(input logic [63:0] img);
    for (int k = 0; k < 8; k++) load_row(k, img[k*8 +: 8]);
  endtask

  task automatic check_mem(input string name, input logic [63:0] img);
    for (int k = 0; k < 8; k++)
      check($sformatf("%s_row%0d", name, k), int'(mem[k]), int'(img[k*8 +: 8]));
  endtask

  task automatic wait_done(input string name);
    logic got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge ph1);
      got = (done === 1'b1);
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got no done pulse, expected one within 400 cycles", name);
    end
    @(posedge ph1);
    #1;
  endtask

  task automatic run(input string name, input int g, input int exp_busy);
    busy_cycles = 0;
    push_gens(g);
    q.push_back(mk_ev(1'b1, 0, 8'(g)));
    start = 1'b1;
    gens  = 8'(g);
    @(posedge ph1);
    #1 start = 1'b0;
    wait_done(name);
    check({name, "_busy_cycles"}, busy_cycles, exp_busy);
    check({name, "_gen_count"}, int'(gen_count), g);
    check({name, "_queue_drained"}, q.size(), 0);
  endtask

  localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
  localparam logic [63:0] GLIDER0 = 64'h0804_0000_0000_000E;
  localparam logic [63:0] GLIDER4 = 64'h0800_0000_0000_1C10;

  initial begin
    reset = 1'b1; start = 1'b0; gens = '0; load_valid = 1'b0;
    load_addr = '0; load_data = '0; rd_addr = 3'd5;
    repeat (2) @(posedge ph1);
    #1 reset = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_regwrite", int'(regwrite), 0);
    check("rst_gen_count", int'(gen_count), 0);
    check("rst_load_ready", int'(load_ready), 1);
    check("idle_ra_readout", int'(ra), 5);

    load_all(BLINK_H);
    run("blink1", 1, 11);
    check_mem("blink1", BLINK_V);
    check("blink1_load_ready", int'(load_ready), 1);

    load_all(BLINK_H);
    run("blink2", 2, 22);
    check_mem("blink2", BLINK_H);

    load_all(GLIDER0);
    run("glider4", 4, 44);
    check_mem("glider4", GLIDER4);

    // Zero generations: straight to DONE, no busy, no writes
    busy_cycles = 0;
    q.push_back(mk_ev(1'b1, 0, 8'd0));
    start = 1'b1;
    gens  = 8'd0;
    @(posedge ph1);
    #1 start = 1'b0;
    check("gens0_done_next_cycle", int'(done), 1);
    @(posedge ph1);
    #1;
    check("gens0_done_one_cycle", int'(done), 0);
    check("gens0_busy_cycles", busy_cycles, 0);
    check("gens0_queue_drained", q.size(), 0);
    check("gens0_gen_count", int'(gen_count), 0);

    // Host load and start while running must be ignored
    load_all(BLINK_H);
    busy_cycles = 0;
    push_gens(1);
    q.push_back(mk_ev(1'b1, 0, 8'd1));
    start = 1'b1;
    gens  = 8'd1;
    @(posedge ph1);
    #1;
    load_valid = 1'b1; load_addr = 3'd5; load_data = 8'hFF; gens = 8'd7;
    repeat (3) begin
      check("calc_load_ready", int'(load_ready), 0);
      check("calc_no_host_write", int'(regwrite), 0);
      @(posedge ph1);
      #1;
    end
    start = 1'b0; load_valid = 1'b0;
    wait_done("ignore");
    check("ignore_busy_cycles", busy_cycles, 11);
    check("ignore_gen_count", int'(gen_count), 1);
    check_mem("ignore", BLINK_V);
    load_row(5, 8'hAA);
    check("idle_load_accepted", int'(mem[5]), 8'hAA);
    run("restart0", 0, 0);

    // Reset mid-run at CALC r=4: only rows 1 and 2 get written
    load_all(BLINK_H);
    q.push_back(mk_ev(1'b0, 1, life(gold[0], gold[1], gold[2])));
    q.push_back(mk_ev(1'b0, 2, life(gold[1], gold[2], gold[3])));
    start = 1'b1;
    gens  = 8'd1;
    @(posedge ph1);
    #1 start = 1'b0;
    repeat (4) @(posedge ph1);
    #1;
    check("abort_ra_at_r4", int'(ra), 4);
    check("abort_write_at_r4", int'(regwrite), 1);
    reset = 1'b1;
    @(posedge ph1);
    #1 reset = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_regwrite", int'(regwrite), 0);
    check("abort_gen_count", int'(gen_count), 0);
    check("abort_load_ready", int'(load_ready), 1);
    busy_cycles = 0;
    repeat (15) @(posedge ph1);
    #1;
    check("abort_no_busy_after", busy_cycles, 0);
    check("abort_queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gol_gen_sequencer.md
Name: gol_gen_sequencer

Overview:
- Controller that sequences the previous-state row register file (ph1/ph2 latch RAM; three combinational reads at ra-1, ra, ra+1; one write) through complete Game of Life generations.
- Accepts host row loads while idle, then runs a requested number of generations.
- Each generation is one row per cycle; computed rows are held back so no old row is overwritten while still needed, including row 0 for the wrap-around.
- The external next-row logic (fed by rd1/rd2/rd3) returns next_row combinationally.

Parameters:
- WIDTH, 8, cells per row (register-file word width).
- REGBITS, 3, row address bits; N = 2**REGBITS rows; REGBITS >= 2 required.
- GENBITS, 8, width of the generation count.

Ports:
- ph1  in  1  single clock; all flops update on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin run; sampled only in IDLE.
- gens  in  GENBITS  generations to run; latched on accepted start.
- load_valid  in  1  host row write request.
- load_addr  in  REGBITS  host row address.
- load_data  in  WIDTH  host row data.
- load_ready  out  1  high only in IDLE.
- rd_addr  in  REGBITS  host read row, driven to ra in IDLE.
- next_row  in  WIDTH  next-state row for current ra (combinational from rd1..rd3).
- ra  out  REGBITS  register-file read centre row.
- regwrite  out  1  register-file write enable.
- wa  out  REGBITS  register-file write row.
- wd  out  WIDTH  register-file write data.
- busy  out  1  high in CALC/FLUSH.
- done  out  1  one-cycle pulse at run end.
- gen_count  out  GENBITS  generations completed in current/last run.

Behaviour:
- Reset:
  - State IDLE; row counter r = 0, flush counter f = 0.
  - nb0, nb1, save0 = 0; gen_count = 0.
  - done = 0, busy = 0, regwrite = 0.
  - Reset mid-run aborts immediately with no further writes; RAM contents are left partially updated and are not repaired.
- Output timing:
  - Outputs decode combinationally from registered state.
  - The only input-to-output paths are the IDLE load/readout paths.
- IDLE:
  - load_ready = 1, ra = rd_addr.
  - regwrite = load_valid, with wa = load_addr and wd = load_data in the same cycle.
  - start = 1: latch gens into gcnt, clear gen_count, r = 0. If gens == 0, go to DONE; else go to CALC. A load in the start cycle is still performed.
- CALC (cycle r, r = 0..N-1):
  - ra = r.
  - Clock edge: nb1 <= nb0, nb0 <= next_row; if r == 0, save0 <= next_row.
  - Write: for r >= 3, regwrite = 1, wa = r-2, wd = nb1 (new row r-2). Otherwise regwrite = 0.
  - Hazard safety: rows read are r-1, r, r+1 mod N, which are never equal to r-2 for r >= 3 and N >= 4.
  - r == N-1: go to FLUSH with f = 0.
  - load_valid and start are ignored.
- FLUSH (f = 0..2), no shifting:
  - f=0: write wa = N-2, wd = nb1.
  - f=1: write wa = N-1, wd = nb0.
  - f=2: write wa = 0, wd = save0; gen_count++, gcnt--.
  - After f=2: if gcnt becomes 0, go to DONE; else go to CALC with r = 0.
- Generation timing: each generation takes exactly N+3 cycles with N writes, in order 1..N-1, then 0.
- DONE: one cycle, done = 1, regwrite = 0, then IDLE.
- Busy: busy = 1 exactly in CALC and FLUSH.
- Counter widths and wrap:
  - Row arithmetic is mod N.
  - gen_count wraps mod 2**GENBITS; gens = 2**GENBITS-1 is legal.

Test Plan:
- Load rows 0..7 = 0 except row 3 = 8'b00011100 (blinker); start with gens=1 -> busy 11 cycles; regwrite wa sequence 1,2,3,4,5,6,7,0; then row2 = row3 = row4 = 8'b00001000 and others 0; done pulse; gen_count = 1.
- Same blinker with gens=2 -> busy 22 cycles; rows return to row3 = 8'b00011100; gen_count = 2.
- Vertical wrap: glider straddling rows 7/0, gens=4, compared against bench golden model -> glider shifted one cell diagonally, wrapped into rows 0/1; proves save0 hold.
- gens=0 start -> no CALC; done the following cycle; busy never asserted; no writes.
- load_valid and start asserted during CALC -> load_ready = 0, no host write reaches wa, run unaffected; both accepted again once IDLE.
- Reset asserted at CALC r=4 of gen 1 -> next cycle IDLE, regwrite = 0, busy = 0, gen_count = 0, no done pulse.
